// File: rtl/alarm_bank_if.sv
// alarm_bank_if: groups the show-time, program, acknowledge and read-back
// signals of the multi-channel alarm engine. The master modport drives the
// engine; the slave modport is the engine itself.
`timescale 1ns/1ps
interface alarm_bank_if #(
    parameter int N_ALARM = 4,
    parameter int IDX_W   = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
);
    logic               tick_1hz;
    logic [7:0]         show_hour;
    logic [7:0]         show_min;
    logic [7:0]         show_sec;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [7:0]         wr_hour;
    logic [7:0]         wr_min;
    logic               wr_on;
    logic               dismiss;
    logic               snooze;
    logic [IDX_W-1:0]   ack_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [N_ALARM-1:0] ring;
    logic               ring_any;
    logic [15:0]        rd_time;
    logic [1:0]         rd_state;

    modport master (
        output tick_1hz, show_hour, show_min, show_sec,
        output wr_en, wr_idx, wr_hour, wr_min, wr_on,
        output dismiss, snooze, ack_idx, rd_idx,
        input  ring, ring_any, rd_time, rd_state
    );

    modport slave (
        input  tick_1hz, show_hour, show_min, show_sec,
        input  wr_en, wr_idx, wr_hour, wr_min, wr_on,
        input  dismiss, snooze, ack_idx, rd_idx,
        output ring, ring_any, rd_time, rd_state
    );
endinterface

// File: rtl/alarm_bank.sv
// alarm_bank: N independently programmable alarm channels with arm/disarm,
// auto-timeout of ringing after RING_SEC ticks, and optional snooze.
// Optional feature macro: ALARM_SNOOZE_EN (snooze input, SNOOZED state and
// the BCD minute adder). Without it, snooze is ignored and rd_time is prog.
`timescale 1ns/1ps
module alarm_bank #(
    parameter int N_ALARM    = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int IDX_W      = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic       CP,
    input  logic       _CR,
    alarm_bank_if.slave bus
);

    typedef enum logic [1:0] {
        S_OFF     = 2'b00,
        S_ARMED   = 2'b01,
        S_RINGING = 2'b10,
        S_SNOOZED = 2'b11
    } state_t;

    // A time is accepted only as valid packed BCD within 00:00 .. 23:59.
    function automatic logic bcd_valid(input logic [7:0] hh, input logic [7:0] mm);
        logic nib_ok;
        nib_ok = (hh[7:4] <= 4'd9) && (hh[3:0] <= 4'd9) &&
                 (mm[7:4] <= 4'd9) && (mm[3:0] <= 4'd9);
        return nib_ok && (hh <= 8'h23) && (mm <= 8'h59);
    endfunction

`ifdef ALARM_SNOOZE_EN
    // Packed BCD (00..99) to binary.
    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return (7'(b[7:4]) * 7'd10) + 7'(b[3:0]);
    endfunction

    // Binary (0..99) to packed BCD.
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Show time plus SNOOZE_MIN minutes, carrying into the hour, 23 -> 00.
    function automatic logic [15:0] snooze_add(input logic [7:0] hh, input logic [7:0] mm);
        logic [6:0] m_bin;
        logic [6:0] h_bin;
        m_bin = bcd2bin(mm) + 7'(SNOOZE_MIN);
        h_bin = bcd2bin(hh);
        if (m_bin >= 7'd60) begin
            m_bin = m_bin - 7'd60;
            h_bin = (h_bin == 7'd23) ? 7'd0 : (h_bin + 7'd1);
        end else begin
            m_bin = m_bin;
        end
        return {bin2bcd(h_bin), bin2bcd(m_bin)};
    endfunction
`endif

    state_t             r_state  [N_ALARM];
    logic [15:0]        r_prog   [N_ALARM];
    logic [15:0]        r_target [N_ALARM];
    logic [7:0]         r_cnt    [N_ALARM];
    logic [N_ALARM-1:0] r_ring;
    logic               r_ring_any;

    state_t             w_state_nxt  [N_ALARM];
    logic [15:0]        w_prog_nxt   [N_ALARM];
    logic [15:0]        w_target_nxt [N_ALARM];
    logic [7:0]         w_cnt_nxt    [N_ALARM];
    logic [N_ALARM-1:0] w_ring_nxt;
    logic               w_wr_ok;
    logic               w_tick_min;
    logic [15:0]        w_rd_time;
    logic [1:0]         w_rd_state;

    assign w_wr_ok    = bus.wr_en && bcd_valid(bus.wr_hour, bus.wr_min);
    assign w_tick_min = bus.tick_1hz && (bus.show_sec == 8'h00);

`ifdef ALARM_SNOOZE_EN
    logic [15:0] w_snooze_t;
    assign w_snooze_t = snooze_add(bus.show_hour, bus.show_min);
`else
    logic w_unused_s;
    assign w_unused_s = bus.snooze;
`endif

    // Per-channel next state: write > dismiss > snooze > timeout > match.
    always_comb begin
        w_ring_nxt = '0;
        for (int i = 0; i < N_ALARM; i++) begin
            w_state_nxt[i]  = r_state[i];
            w_prog_nxt[i]   = r_prog[i];
            w_target_nxt[i] = r_target[i];
            w_cnt_nxt[i]    = r_cnt[i];
            if (w_wr_ok && (bus.wr_idx == IDX_W'(i))) begin
                w_prog_nxt[i]   = {bus.wr_hour, bus.wr_min};
                w_target_nxt[i] = {bus.wr_hour, bus.wr_min};
                w_cnt_nxt[i]    = 8'd0;
                w_state_nxt[i]  = bus.wr_on ? S_ARMED : S_OFF;
            end else if (bus.dismiss && (bus.ack_idx == IDX_W'(i)) &&
                         ((r_state[i] == S_RINGING) || (r_state[i] == S_SNOOZED))) begin
                w_state_nxt[i]  = S_ARMED;
                w_target_nxt[i] = r_prog[i];
`ifdef ALARM_SNOOZE_EN
            end else if (bus.snooze && (bus.ack_idx == IDX_W'(i)) &&
                         (r_state[i] == S_RINGING)) begin
                w_state_nxt[i]  = S_SNOOZED;
                w_target_nxt[i] = w_snooze_t;
`endif
            end else if (bus.tick_1hz && (r_state[i] == S_RINGING)) begin
                // The entry tick is not counted; stop on the RING_SEC-th tick.
                if (r_cnt[i] == 8'(RING_SEC - 1)) begin
                    w_state_nxt[i]  = S_ARMED;
                    w_target_nxt[i] = r_prog[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 8'd1;
                end
            end else if (w_tick_min && ({bus.show_hour, bus.show_min} == r_target[i]) &&
                         ((r_state[i] == S_ARMED) || (r_state[i] == S_SNOOZED))) begin
                w_state_nxt[i] = S_RINGING;
                w_cnt_nxt[i]   = 8'd0;
            end else begin
                w_state_nxt[i] = r_state[i];
            end
            w_ring_nxt[i] = (w_state_nxt[i] == S_RINGING);
        end
    end

    // Channel registers plus registered ring flags; reset clears programming.
    always_ff @(posedge CP or posedge _CR) begin
        if (_CR) begin
            for (int i = 0; i < N_ALARM; i++) begin
                r_state[i]  <= S_OFF;
                r_prog[i]   <= 16'h0000;
                r_target[i] <= 16'h0000;
                r_cnt[i]    <= 8'd0;
            end
            r_ring     <= '0;
            r_ring_any <= 1'b0;
        end else begin
            for (int i = 0; i < N_ALARM; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_prog[i]   <= w_prog_nxt[i];
                r_target[i] <= w_target_nxt[i];
                r_cnt[i]    <= w_cnt_nxt[i];
            end
            r_ring     <= w_ring_nxt;
            r_ring_any <= |w_ring_nxt;
        end
    end

    // Zero-latency read-back; an out-of-range index reads as zero.
    always_comb begin
        w_rd_time  = 16'h0000;
        w_rd_state = 2'b00;
        if (int'(bus.rd_idx) < N_ALARM) begin
`ifdef ALARM_SNOOZE_EN
            w_rd_time = r_target[bus.rd_idx];
`else
            w_rd_time = r_prog[bus.rd_idx];
`endif
            w_rd_state = r_state[bus.rd_idx];
        end else begin
            w_rd_time  = 16'h0000;
            w_rd_state = 2'b00;
        end
    end

    assign bus.ring     = r_ring;
    assign bus.ring_any = r_ring_any;
    assign bus.rd_time  = w_rd_time;
    assign bus.rd_state = w_rd_state;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed scoreboard bench for alarm_bank (N_ALARM=4,
// RING_SEC=60, SNOOZE_MIN=5). Snooze checks depend on ALARM_SNOOZE_EN.
`timescale 1ns/1ps
module tb_alarm_bank;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alarm_bank_if #(.N_ALARM(N)) bus();

    alarm_bank #(.N_ALARM(N), .RING_SEC(60), .SNOOZE_MIN(5)) dut (
        .CP  (clk),
        ._CR (rst),
        .bus (bus.slave)
    );

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.show_hour = h;
        bus.show_min  = m;
        bus.show_sec  = s;
        bus.tick_1hz  = 1'b1;
        step();
        bus.tick_1hz  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [7:0] h, input logic [7:0] m, input logic on);
        bus.wr_idx  = idx;
        bus.wr_hour = h;
        bus.wr_min  = m;
        bus.wr_on   = on;
        bus.wr_en   = 1'b1;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic dis(input logic [1:0] idx);
        bus.ack_idx = idx;
        bus.dismiss = 1'b1;
        step();
        bus.dismiss = 1'b0;
    endtask

    task automatic snz(input logic [1:0] idx);
        bus.ack_idx = idx;
        bus.snooze  = 1'b1;
        step();
        bus.snooze  = 1'b0;
    endtask

    task automatic chk_rd(input logic [1:0] idx, input string t, input logic [15:0] et, input logic [1:0] es);
        bus.rd_idx = idx;
        #1;
        push({t, "_time"}, 32'(et));
        chk(32'(bus.rd_time));
        push({t, "_state"}, 32'(es));
        chk(32'(bus.rd_state));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.tick_1hz  = 1'b0;
        bus.show_hour = 8'h00;
        bus.show_min  = 8'h00;
        bus.show_sec  = 8'h00;
        bus.wr_en     = 1'b0;
        bus.wr_idx    = 2'd0;
        bus.wr_hour   = 8'h00;
        bus.wr_min    = 8'h00;
        bus.wr_on     = 1'b0;
        bus.dismiss   = 1'b0;
        bus.snooze    = 1'b0;
        bus.ack_idx   = 2'd0;
        bus.rd_idx    = 2'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // reset state
        push("rst_ring", 32'h0);
        chk(32'(bus.ring));
        push("rst_any", 32'h0);
        chk(32'(bus.ring_any));
        for (int i = 0; i < N; i++) chk_rd(2'(i), "rst", 16'h0000, 2'b00);

        // program ch0 07:30 and ring it
        wr(2'd0, 8'h07, 8'h30, 1'b1);
        chk_rd(2'd0, "wr0", 16'h0730, 2'b01);
        push("pre_match", 32'h0);
        tick(8'h07, 8'h29, 8'h00);
        chk(32'(bus.ring));
        push("match_ring", 32'h1);
        tick(8'h07, 8'h30, 8'h00);
        chk(32'(bus.ring));
        chk_rd(2'd0, "ringing", 16'h0730, 2'b10);

        // ring length: exactly 60 ticks after the entry tick
        n = 0;
        push("ring_len", 32'd60);
        for (int k = 0; k < 100; k++) begin
            if (bus.ring[0] !== 1'b1) break;
            tick(8'h07, 8'h30, 8'h01);
            n++;
        end
        chk(32'(n));
        chk_rd(2'd0, "timeout", 16'h0730, 2'b01);
        push("timeout_any", 32'h0);
        chk(32'(bus.ring_any));

        // ch1 23:58 and snooze across midnight
        wr(2'd1, 8'h23, 8'h58, 1'b1);
        push("ch1_ring", 32'h2);
        tick(8'h23, 8'h58, 8'h00);
        chk(32'(bus.ring));
        bus.show_hour = 8'h23;
        bus.show_min  = 8'h58;
        bus.show_sec  = 8'h10;
`ifdef ALARM_SNOOZE_EN
        push("snz_ring", 32'h0);
        snz(2'd1);
        chk(32'(bus.ring));
        chk_rd(2'd1, "snoozed", 16'h0003, 2'b11);
        push("snz_early", 32'h0);
        tick(8'h00, 8'h02, 8'h00);
        chk(32'(bus.ring));
        push("snz_again", 32'h2);
        tick(8'h00, 8'h03, 8'h00);
        chk(32'(bus.ring));
        chk_rd(2'd1, "resnz", 16'h0003, 2'b10);
`else
        push("nosnz_ring", 32'h2);
        snz(2'd1);
        chk(32'(bus.ring));
        chk_rd(2'd1, "nosnz", 16'h2358, 2'b10);
`endif
        push("dis1_ring", 32'h0);
        dis(2'd1);
        chk(32'(bus.ring));
        chk_rd(2'd1, "dis1", 16'h2358, 2'b01);

        // concurrent ring on ch2/ch3
        wr(2'd2, 8'h12, 8'h00, 1'b1);
        wr(2'd3, 8'h12, 8'h00, 1'b1);
        push("dual_ring", 32'hC);
        tick(8'h12, 8'h00, 8'h00);
        chk(32'(bus.ring));
        push("dis2_ring", 32'h8);
        dis(2'd2);
        chk(32'(bus.ring));
        push("dis2_any", 32'h1);
        chk(32'(bus.ring_any));
        push("dis3_any", 32'h0);
        dis(2'd3);
        chk(32'(bus.ring_any));

        // invalid writes are ignored
        wr(2'd0, 8'h24, 8'h00, 1'b1);
        chk_rd(2'd0, "bad_hr", 16'h0730, 2'b01);
        wr(2'd0, 8'h12, 8'h5A, 1'b1);
        chk_rd(2'd0, "bad_min", 16'h0730, 2'b01);

        // write-off beats dismiss in the same cycle
        push("ch0_ring2", 32'h1);
        tick(8'h07, 8'h30, 8'h00);
        chk(32'(bus.ring));
        bus.ack_idx = 2'd0;
        bus.dismiss = 1'b1;
        push("wr_off_ring", 32'h0);
        wr(2'd0, 8'h08, 8'h00, 1'b0);
        bus.dismiss = 1'b0;
        chk(32'(bus.ring));
        chk_rd(2'd0, "wr_off", 16'h0800, 2'b00);

        // asynchronous reset while ringing
        wr(2'd0, 8'h07, 8'h30, 1'b1);
        push("ch0_ring3", 32'h1);
        tick(8'h07, 8'h30, 8'h00);
        chk(32'(bus.ring));
        rst = 1'b1;
        #1;
        push("async_ring", 32'h0);
        chk(32'(bus.ring));
        push("async_any", 32'h0);
        chk(32'(bus.ring_any));
        #3 rst = 1'b0;
        step();
        for (int i = 0; i < N; i++) chk_rd(2'(i), "post_rst", 16'h0000, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
